// File: rtl/datapath_sequencer_pkg.sv
// Shared definitions for the datapath issue sequencer: instruction field layout,
// FSM states and register-file constants.
package datapath_pkg;

  localparam int INSTR_W     = 24;
  localparam int REG_W       = 4;
  localparam int NUM_REGS    = 16;
  localparam int DEFAULT_LAT = 2;

  localparam int OP_LSB   = 21;
  localparam int OP_W     = 3;
  localparam int FORM_BIT = 20;
  localparam int VEC_LSB  = 18;
  localparam int VEC_W    = 2;
  localparam int A_LSB    = 14;
  localparam int B_LSB    = 10;
  localparam int C_LSB    = 6;
  localparam int D_LSB    = 2;
  localparam int WR_LSB   = 0;
  localparam int WR_W     = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] idx);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// Instruction handshake between an instruction source and the sequencer.
interface datapath_sequencer_if;
  import datapath_pkg::*;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);

endinterface

// File: rtl/datapath_sequencer_scoreboard.sv
// Register write scoreboard: each inserted mask stays visible in busy_mask for
// exactly LAT cycles, shifting every cycle independent of stalls.
module reg_scoreboard
  import datapath_pkg::*;
#(
  parameter int LAT = DEFAULT_LAT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REGS-1:0] insert,
  output logic [NUM_REGS-1:0] busy_mask
);

  logic [NUM_REGS-1:0] stage_r [LAT];

  // Shift pipeline of in-flight write masks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        stage_r[i] <= 16'h0000;
      end
    end else begin
      stage_r[0] <= insert;
      for (int i = 1; i < LAT; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  // OR of all stages
  always_comb begin
    busy_mask = 16'h0000;
    for (int i = 0; i < LAT; i++) begin
      busy_mask = busy_mask | stage_r[i];
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Issue controller: accepts instructions, expands vectors into per-element beats
// and holds back any beat whose registers collide with in-flight writes.
module datapath_sequencer
  import datapath_pkg::*;
#(
  parameter int LAT = DEFAULT_LAT,
  parameter int IW  = INSTR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  datapath_sequencer_if.slave   bus,
  input  logic [REG_W-1:0]      zero_reg_cfg,
  output logic [OP_W-1:0]       dp_op,
  output logic                  dp_form,
  output logic [VEC_W-1:0]      dp_vec,
  output logic [REG_W-1:0]      dp_A,
  output logic [REG_W-1:0]      dp_B,
  output logic [REG_W-1:0]      dp_C,
  output logic [REG_W-1:0]      dp_D,
  output logic [WR_W-1:0]       dp_write,
  output logic [REG_W-1:0]      dp_zero_reg,
  output logic                  dp_issue,
  output logic                  busy,
  output logic [15:0]           stall_count
);

  state_t              state_r;
  state_t              state_nxt;
  logic [IW-1:0]       instr_r;
  logic [VEC_W-1:0]    beat_r;

  logic [OP_W-1:0]     op_s;
  logic                form_s;
  logic [VEC_W-1:0]    vec_s;
  logic [WR_W-1:0]     wr_s;
  logic [REG_W-1:0]    a_s, b_s, c_s, d_s;
  logic [NUM_REGS-1:0] busy_mask_s;
  logic [NUM_REGS-1:0] write_mask_s;
  logic [NUM_REGS-1:0] insert_s;
  logic                hazard_s;
  logic                issue_s;
  logic                last_s;
  logic                accept_s;

  // Zero register is architecturally constant, so it never blocks an issue
  function automatic logic reg_hit(input logic [NUM_REGS-1:0] mask,
                                   input logic [REG_W-1:0]    idx,
                                   input logic [REG_W-1:0]    zr);
    return (idx != zr) && mask[idx];
  endfunction

  assign op_s   = instr_r[OP_LSB +: OP_W];
  assign form_s = instr_r[FORM_BIT];
  assign vec_s  = instr_r[VEC_LSB +: VEC_W];
  assign wr_s   = instr_r[WR_LSB +: WR_W];
  assign a_s    = instr_r[A_LSB +: REG_W] + {2'b00, beat_r};
  assign b_s    = instr_r[B_LSB +: REG_W] + {2'b00, beat_r};
  assign c_s    = instr_r[C_LSB +: REG_W] + {2'b00, beat_r};
  assign d_s    = instr_r[D_LSB +: REG_W] + {2'b00, beat_r};

  assign bus.instr_ready = (state_r == IDLE) & ~rst;
  assign accept_s        = bus.instr_valid & bus.instr_ready;
  assign dp_zero_reg     = zero_reg_cfg;
  assign busy            = (state_r == ISSUE) | (busy_mask_s != 16'h0000);

  // Hazard detection, write mask and issue decision for the current beat
  always_comb begin
    hazard_s = reg_hit(busy_mask_s, b_s, zero_reg_cfg)
             | reg_hit(busy_mask_s, c_s, zero_reg_cfg)
             | (wr_s[0] & reg_hit(busy_mask_s, a_s, zero_reg_cfg))
             | (wr_s[1] & reg_hit(busy_mask_s, d_s, zero_reg_cfg));
    write_mask_s = 16'h0000;
    if (wr_s[0] && (a_s != zero_reg_cfg)) begin
      write_mask_s = write_mask_s | reg_onehot(a_s);
    end else begin
      write_mask_s = write_mask_s;
    end
    if (wr_s[1] && (d_s != zero_reg_cfg)) begin
      write_mask_s = write_mask_s | reg_onehot(d_s);
    end else begin
      write_mask_s = write_mask_s;
    end
    issue_s  = (state_r == ISSUE) & ~hazard_s;
    last_s   = (beat_r == vec_s);
    insert_s = issue_s ? write_mask_s : 16'h0000;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt = ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (issue_s && last_s) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, latched instruction and beat index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      instr_r <= 24'h000000;
      beat_r  <= 2'd0;
    end else begin
      state_r <= state_nxt;
      if (accept_s) begin
        instr_r <= bus.instr;
        beat_r  <= 2'd0;
      end else if (issue_s && !last_s) begin
        beat_r <= beat_r + 2'd1;
      end
    end
  end

  // Registered datapath drives; bubbles present all-zero controls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_op    <= 3'd0;
      dp_form  <= 1'b0;
      dp_vec   <= 2'd0;
      dp_A     <= 4'd0;
      dp_B     <= 4'd0;
      dp_C     <= 4'd0;
      dp_D     <= 4'd0;
      dp_write <= 2'd0;
      dp_issue <= 1'b0;
    end else if (issue_s) begin
      dp_op    <= op_s;
      dp_form  <= form_s;
      dp_vec   <= vec_s;
      dp_A     <= a_s;
      dp_B     <= b_s;
      dp_C     <= c_s;
      dp_D     <= d_s;
      dp_write <= wr_s;
      dp_issue <= 1'b1;
    end else begin
      dp_op    <= 3'd0;
      dp_form  <= 1'b0;
      dp_vec   <= 2'd0;
      dp_A     <= 4'd0;
      dp_B     <= 4'd0;
      dp_C     <= 4'd0;
      dp_D     <= 4'd0;
      dp_write <= 2'd0;
      dp_issue <= 1'b0;
    end
  end

  // Saturating hazard stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= 16'h0000;
    end else if ((state_r == ISSUE) && hazard_s && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'h0001;
    end
  end

  reg_scoreboard #(.LAT(LAT)) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .insert    (insert_s),
    .busy_mask (busy_mask_s)
  );

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: expected beats are queued when an
// instruction is sent and compared whenever the datapath sees dp_issue.
module tb_datapath_sequencer;
  import datapath_pkg::*;

  typedef struct packed {
    logic [2:0] op;
    logic       form;
    logic [1:0] vec;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
    logic [1:0] wr;
  } beat_t;

  logic       clk;
  logic       rst;
  logic [3:0] zero_reg_cfg;
  logic [2:0] dp_op;
  logic       dp_form;
  logic [1:0] dp_vec;
  logic [3:0] dp_A, dp_B, dp_C, dp_D;
  logic [1:0] dp_write;
  logic [3:0] dp_zero_reg;
  logic       dp_issue;
  logic       busy;
  logic [15:0] stall_count;

  int    checks;
  int    failures;
  beat_t exp_q[$];

  datapath_sequencer_if bus ();

  datapath_sequencer #(.LAT(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .zero_reg_cfg (zero_reg_cfg),
    .dp_op        (dp_op),
    .dp_form      (dp_form),
    .dp_vec       (dp_vec),
    .dp_A         (dp_A),
    .dp_B         (dp_B),
    .dp_C         (dp_C),
    .dp_D         (dp_D),
    .dp_write     (dp_write),
    .dp_zero_reg  (dp_zero_reg),
    .dp_issue     (dp_issue),
    .busy         (busy),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction, queue its expected beats, return #1 after the accept edge
  task automatic send(input logic [2:0] op, input logic form, input logic [1:0] vec,
                      input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                      input logic [3:0] d, input logic [1:0] wr);
    beat_t bt;
    int    n;
    n = 0;
    while (bus.instr_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("send_ready_timeout", 32'd0, 32'd1);
    bus.instr       = {op, form, vec, a, b, c, d, wr};
    bus.instr_valid = 1'b1;
    for (int k = 0; k <= int'(vec); k++) begin
      bt.op   = op;
      bt.form = form;
      bt.vec  = vec;
      bt.a    = a + 4'(k);
      bt.b    = b + 4'(k);
      bt.c    = c + 4'(k);
      bt.d    = d + 4'(k);
      bt.wr   = wr;
      exp_q.push_back(bt);
    end
    tick();
    bus.instr_valid = 1'b0;
    bus.instr       = 24'h000000;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard side: every issued beat must match the oldest expected beat
  always @(negedge clk) begin
    if (dp_issue === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", {8'h00, dp_op, dp_form, dp_vec, dp_A, dp_B, dp_C, dp_D, dp_write}, 32'hDEAD);
      end else begin
        check("beat", {8'h00, dp_op, dp_form, dp_vec, dp_A, dp_B, dp_C, dp_D, dp_write},
              {8'h00, exp_q.pop_front()});
      end
    end
  end

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b0;
    zero_reg_cfg    = 4'd0;
    bus.instr_valid = 1'b0;
    bus.instr       = 24'h000000;
    #1 rst = 1'b1;
    #2;
    check("rst_dp_issue", {31'd0, dp_issue}, 32'd0);
    check("rst_ready", {31'd0, bus.instr_ready}, 32'd0);
    check("rst_stall", {16'd0, stall_count}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, bus.instr_ready}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // Scalar issue
    send(3'd3, 1'b0, 2'd0, 4'd5, 4'd1, 4'd2, 4'd0, 2'b01);
    check("scalar_busy_accepted", {31'd0, busy}, 32'd1);
    tick();
    check("scalar_issue", {31'd0, dp_issue}, 32'd1);
    check("scalar_op", {29'd0, dp_op}, 32'd3);
    check("scalar_A", {28'd0, dp_A}, 32'd5);
    check("scalar_ready", {31'd0, bus.instr_ready}, 32'd1);
    tick();
    check("scalar_busy_e2", {31'd0, busy}, 32'd1);
    tick();
    check("scalar_busy_e3", {31'd0, busy}, 32'd0);

    // RAW stall on r5
    send(3'd1, 1'b0, 2'd0, 4'd5, 4'd1, 4'd2, 4'd0, 2'b01);
    tick();
    check("raw_i1_issue", {31'd0, dp_issue}, 32'd1);
    send(3'd2, 1'b0, 2'd0, 4'd6, 4'd5, 4'd3, 4'd0, 2'b01);
    tick();
    check("raw_bubble", {31'd0, dp_issue}, 32'd0);
    check("raw_bubble_op", {29'd0, dp_op}, 32'd0);
    check("raw_stall", {16'd0, stall_count}, 32'd1);
    tick();
    check("raw_i2_issue", {31'd0, dp_issue}, 32'd1);
    check("raw_i2_B", {28'd0, dp_B}, 32'd5);
    wait_idle();

    // WAW stall: D write then A write to r7
    send(3'd1, 1'b1, 2'd0, 4'd2, 4'd3, 4'd4, 4'd7, 2'b10);
    tick();
    send(3'd2, 1'b0, 2'd0, 4'd7, 4'd3, 4'd4, 4'd8, 2'b01);
    tick();
    check("waw_bubble", {31'd0, dp_issue}, 32'd0);
    check("waw_stall", {16'd0, stall_count}, 32'd2);
    tick();
    check("waw_i2_issue", {31'd0, dp_issue}, 32'd1);
    wait_idle();

    // Vector wrap, write=00
    send(3'd4, 1'b0, 2'd3, 4'd14, 4'd8, 4'd3, 4'd7, 2'b00);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] ea;
      logic [3:0] eb;
      ea = 4'd14 + 4'(k);
      eb = 4'd8 + 4'(k);
      tick();
      check("vec_issue", {31'd0, dp_issue}, 32'd1);
      check("vec_A", {28'd0, dp_A}, {28'd0, ea});
      check("vec_B", {28'd0, dp_B}, {28'd0, eb});
      check("vec_ready", {31'd0, bus.instr_ready}, (k == 3) ? 32'd1 : 32'd0);
    end
    tick();
    check("vec_done", {31'd0, dp_issue}, 32'd0);
    wait_idle();

    // Zero register writes/reads never stall
    send(3'd5, 1'b0, 2'd0, 4'd0, 4'd1, 4'd2, 4'd0, 2'b01);
    tick();
    send(3'd6, 1'b0, 2'd0, 4'd3, 4'd0, 4'd0, 4'd0, 2'b01);
    tick();
    check("zero_issue", {31'd0, dp_issue}, 32'd1);
    check("zero_op", {29'd0, dp_op}, 32'd6);
    check("zero_stall", {16'd0, stall_count}, 32'd2);
    check("zero_copy", {28'd0, dp_zero_reg}, 32'd0);
    wait_idle();
    check("queue_drained", exp_q.size(), 32'd0);

    // Reset during beat 1 of a vector
    send(3'd7, 1'b0, 2'd3, 4'd0, 4'd4, 4'd8, 4'd12, 2'b01);
    tick();
    check("mid_beat0", {31'd0, dp_issue}, 32'd1);
    tick();
    check("mid_beat1_A", {28'd0, dp_A}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_issue", {31'd0, dp_issue}, 32'd0);
    check("mid_rst_dp", {8'h00, dp_op, dp_form, dp_vec, dp_A, dp_B, dp_C, dp_D, dp_write}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.instr_ready}, 32'd0);
    check("mid_rst_stall", {16'd0, stall_count}, 32'd0);
    check("mid_rst_pending", exp_q.size(), 32'd3);
    exp_q.delete();
    tick();
    rst = 1'b0;
    #1;
    check("mid_post_busy", {31'd0, busy}, 32'd0);
    check("mid_post_ready", {31'd0, bus.instr_ready}, 32'd1);
    for (int k = 0; k < 6; k++) tick();
    check("mid_no_more_beats", {31'd0, dp_issue}, 32'd0);
    check("mid_still_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
